aso_arcsin: RTL and testbench
=============================

Name: aso_arcsin

Overview:
- Pipelined fixed-point arcsine approximator in the emphasis front-end.
- Takes one signed Q0.10 sample per clock and returns p ≈ arcsin(z) in signed Q1.10.
- Uses the odd polynomial p = z + z³·(C3 + C5·z²), evaluated in Horner form over 3 register stages.
- Latency 3 cycles, throughput 1 sample/cycle, no handshake.

Parameters:
- C3, default 171, Q0.10 coefficient ≈ 1/6 (unsigned, 0..1023).
- C5, default 77, Q0.10 coefficient ≈ 3/40 (unsigned, 0..1023).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high; clears all pipeline registers
- z  in  11  signed Q0.10 input; value = z·2^-10, range [-1, 1)
- p  out  12  signed Q1.10 result; value = p·2^-10, registered output

Behaviour:
- Scaling: every ">>10" below is an arithmetic right shift, i.e. floor toward -inf. There is no rounding and no saturation.
- Stage 1, registered on clock edge k:
  - z1 <= z
  - w1 <= (z*z)>>10, unsigned, 11 bits, range 0..1024
- Stage 2, edge k+1:
  - z2 <= z1
  - t = C3 + ((C5*w1)>>10), combinational, 9 bits unsigned
  - s2 <= (w1*t)>>10, unsigned, max 248
- Stage 3, edge k+2:
  - p <= z2 + ((z2*s2)>>10), signed
- Latency: z sampled at edge k appears on p right after edge k+2. p is only ever driven from a register.
- Width guarantee: over the full input range p lies in [-1272, 1268], so it never overflows 12 bits. Internal products must use full-precision widths (22 bits for z*z, 20 bits for z2*s2) before shifting.
- Sign asymmetry: floor shifting makes negative results differ from the mirror of positive results by up to 1 LSB (z=-512 gives -536, z=+512 gives 535). This is required behaviour.
- Reset:
  - Asserting rst clears z1, w1, z2, s2 and p to 0 immediately, without waiting for a clock.
  - While rst is high, p = 0.
  - After release, the first valid output appears 3 edges after the first sampled input; before that p shows results of zero-filled stages (0).
- Reset mid-stream: in-flight samples are discarded with no recovery.
- z held constant: p settles to a constant after 3 edges.

Decomposition:
- Package aso_pkg holds:
  - width constants: Z_W=11, P_W=12, FRAC=10
  - default coefficients C3=171, C5=77
  - typedefs: z_t (logic signed [10:0]), p_t (logic signed [11:0])
- One sub-module, mul_shr: a parameterized signed/unsigned multiply followed by an arithmetic >>FRAC. It is instantiated four times: z*z, C5*w1, w1*t, z2*s2.
- The pipeline registers live in the top module with a single async-reset always_ff.

Test Plan:
- Reset: rst=1 with z arbitrary -> p=0 asynchronously. Release rst, hold z=0 -> p stays 0.
- Latency: single sample z=512, zeros around it -> p=535 exactly on the 3rd edge after sampling and 0 on the other cycles.
- Ramp: z=0,128,256,384,512,640,768,896 on consecutive cycles -> p=0,128,258,393,535,688,858,1049 on consecutive cycles, starting 3 cycles later.
- Negative/extremes:
  - z=-512 -> -536
  - z=-1024 -> -1272
  - z=1023 -> 1268 (no overflow)
  - z=-128 -> -129
- Mid-stream reset: assert rst asynchronously between edges during the ramp -> p=0 at once; ramp samples in flight never appear after release.
- Back-to-back alternation: z=+896 and -896 on alternating cycles -> p alternates 1049 and -1050 with no stage cross-talk.

Source files
------------

// File: rtl/aso_pkg.sv
// Shared widths, default coefficients and sample types for the arcsine approximator.
package aso_pkg;

   localparam int unsigned Z_W    = 11;
   localparam int unsigned P_W    = 12;
   localparam int unsigned FRAC   = 10;
   localparam int unsigned DEF_C3 = 171;
   localparam int unsigned DEF_C5 = 77;

   typedef logic signed [Z_W-1:0] z_t;
   typedef logic signed [P_W-1:0] p_t;

endpackage

// File: rtl/mul_shr.sv
// Full-precision multiply of two optionally signed operands, then arithmetic >> FRAC.
module mul_shr
   import aso_pkg::*;
#(
   parameter int unsigned AW       = 11,
   parameter int unsigned BW       = 11,
   parameter int unsigned OW       = 11,
   parameter bit          A_SIGNED = 1'b1,
   parameter bit          B_SIGNED = 1'b1
) (
   input  logic [AW-1:0] a,
   input  logic [BW-1:0] b,
   output logic [OW-1:0] y
);

   localparam int unsigned PW = AW + BW + 2;

   logic signed [AW:0]    a_x;
   logic signed [BW:0]    b_x;
   logic signed [PW-1:0]  prod;

   // One guard bit lets signed and unsigned operands share a signed multiplier.
   assign a_x  = A_SIGNED ? $signed({a[AW-1], a}) : $signed({1'b0, a});
   assign b_x  = B_SIGNED ? $signed({b[BW-1], b}) : $signed({1'b0, b});
   assign prod = PW'(a_x) * PW'(b_x);
   assign y    = OW'(prod >>> FRAC);

endmodule

// File: rtl/aso_arcsin.sv
// Three-stage pipelined arcsine: p = z + z^3 * (C3 + C5 * z^2), Q0.10 in, Q1.10 out.
module aso_arcsin
   import aso_pkg::*;
#(
   parameter int unsigned C3 = DEF_C3,
   parameter int unsigned C5 = DEF_C5
) (
   input  logic clk,
   input  logic rst,
   input  z_t   z,
   output p_t   p
);

   localparam logic [9:0] C3_Q = 10'(C3);
   localparam logic [9:0] C5_Q = 10'(C5);

   z_t          z1, z2;
   logic [10:0] w_next, w1;
   logic [9:0]  c5w;
   logic [8:0]  t;
   logic [7:0]  s_next, s2;
   logic [11:0] zs;
   p_t          p_next;

   mul_shr #(
      .AW(Z_W), .BW(Z_W), .OW(11), .A_SIGNED(1'b1), .B_SIGNED(1'b1)
   ) u_zz (
      .a(z), .b(z), .y(w_next)
   );

   mul_shr #(
      .AW(10), .BW(11), .OW(10), .A_SIGNED(1'b0), .B_SIGNED(1'b0)
   ) u_c5w (
      .a(C5_Q), .b(w1), .y(c5w)
   );

   assign t = 9'(C3_Q + c5w);

   mul_shr #(
      .AW(11), .BW(9), .OW(8), .A_SIGNED(1'b0), .B_SIGNED(1'b0)
   ) u_ws (
      .a(w1), .b(t), .y(s_next)
   );

   mul_shr #(
      .AW(Z_W), .BW(8), .OW(P_W), .A_SIGNED(1'b1), .B_SIGNED(1'b0)
   ) u_zs (
      .a(z2), .b(s2), .y(zs)
   );

   assign p_next = p_t'(z2) + p_t'(zs);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z1 <= '0;
         w1 <= '0;
         z2 <= '0;
         s2 <= '0;
         p  <= '0;
      end else begin
         z1 <= z;
         w1 <= w_next;
         z2 <= z1;
         s2 <= s_next;
         p  <= p_next;
      end
   end

endmodule

// File: tb/tb_aso_arcsin.sv
// Directed bench for aso_arcsin; expected results queue up as samples are driven.
module tb_aso_arcsin;

   logic               clk;
   logic               rst;
   logic signed [10:0] z;
   logic signed [11:0] p;

   int compared   = 0;
   int mismatched = 0;
   int exp_q[$];

   aso_arcsin u_dut (
      .clk(clk),
      .rst(rst),
      .z  (z),
      .p  (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int expected);
      compared++;
      assert (int'(p) === expected)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, int'(p), expected);
      end
   endtask

   // Drive one sample with its expected result, clock once, then compare the head of the queue.
   task automatic step(input int zin, input int expected, input string tag);
      int head;
      z = 11'(zin);
      exp_q.push_back(expected);
      @(posedge clk);
      #1;
      head = exp_q.pop_front();
      check(tag, head);
   endtask

   // After reset release two zero-filled stages still sit ahead of the first new sample.
   task automatic prime_queue();
      exp_q.delete();
      exp_q.push_back(0);
      exp_q.push_back(0);
   endtask

   initial begin
      rst = 1'b0;
      z   = 11'sd300;
      #1 rst = 1'b1;
      #1 check("reset_async", 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("reset_hold", 0);
      end
      @(negedge clk);
      rst = 1'b0;
      prime_queue();

      for (int i = 0; i < 3; i++) step(0, 0, "zero_idle");

      step(512, 535, "latency");
      for (int i = 0; i < 5; i++) step(0, 0, "latency_gap");

      step(0,   0,    "ramp_0");
      step(128, 128,  "ramp_128");
      step(256, 258,  "ramp_256");
      step(384, 393,  "ramp_384");
      step(512, 535,  "ramp_512");
      step(640, 688,  "ramp_640");
      step(768, 858,  "ramp_768");
      step(896, 1049, "ramp_896");

      step(-512,  -536,  "neg_512");
      step(-1024, -1272, "neg_1024");
      step(1023,  1268,  "pos_1023");
      step(-128,  -129,  "neg_128");
      for (int i = 0; i < 3; i++) step(0, 0, "extreme_flush");

      for (int i = 0; i < 4; i++) begin
         step(896,  1049,  "alt_pos");
         step(-896, -1050, "alt_neg");
      end
      for (int i = 0; i < 2; i++) step(0, 0, "alt_flush");

      // Ramp interrupted by an asynchronous reset between edges.
      step(128, 128, "mid_ramp_128");
      step(256, 258, "mid_ramp_256");
      step(384, 393, "mid_ramp_384");
      z = 11'sd512;
      #2 rst = 1'b1;
      #1 check("mid_reset_async", 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("mid_reset_hold", 0);
      end
      @(negedge clk);
      rst = 1'b0;
      prime_queue();
      for (int i = 0; i < 5; i++) step(0, 0, "post_reset_zero");

      step(1023, 1268, "post_reset_1023");
      for (int i = 0; i < 3; i++) step(0, 0, "final_flush");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
